// File: rtl/pspin_pkt_match_mc_pkg.sv
// Shared encodings for the packet matcher: FSM states and per-ruleset combine modes.
package pspin_pkt_match_mc_pkg;

  localparam logic MODE_AND = 1'b0;
  localparam logic MODE_OR  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    MATCH = 3'd2,
    FLUSH = 3'd3,
    PASS  = 3'd4
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pspin_match_unit.sv
// Single-rule compare against the captured header window, including the
// disabled-rule identity value and the out-of-window rejection.
module pspin_match_unit
  import pspin_pkt_match_mc_pkg::*;
#(
  parameter int UMATCH_WIDTH       = 32,
  parameter int AXIS_IF_DATA_WIDTH = 512,
  parameter int UMATCH_HDR_BEATS   = 2,
  parameter int CNT_W              = 2
) (
  input  logic [UMATCH_HDR_BEATS*AXIS_IF_DATA_WIDTH-1:0] hdr,
  input  logic [CNT_W-1:0]                               nbeats,
  input  logic                                           mode,
  input  logic [UMATCH_WIDTH-1:0]                        idx,
  input  logic [UMATCH_WIDTH-1:0]                        mask,
  input  logic [UMATCH_WIDTH-1:0]                        rule_start,
  input  logic [UMATCH_WIDTH-1:0]                        rule_end,
  output logic                                           en,
  output logic                                           hit
);

  localparam int WPB = AXIS_IF_DATA_WIDTH / UMATCH_WIDTH;
  localparam int NW  = UMATCH_HDR_BEATS * WPB;

  logic [UMATCH_WIDTH-1:0] word;
  logic [UMATCH_WIDTH-1:0] masked;
  logic                    in_win;

  always_comb begin
    word = '0;
    for (int k = 0; k < NW; k++)
      if (64'(idx) == 64'(k)) word = hdr[k*UMATCH_WIDTH +: UMATCH_WIDTH];
  end

  // Only words inside beats actually captured for this packet are eligible.
  assign in_win = 64'(idx) < (64'(nbeats) * 64'(WPB));
  assign masked = word & mask;
  assign en     = |mask;

  always_comb begin
    if (!en) hit = (mode == MODE_AND);
    else     hit = in_win && (masked >= rule_start) && (masked <= rule_end);
  end

endmodule

// File: rtl/pspin_pkt_match_mc.sv
// Multi-ruleset header matcher: buffers the header window, picks the lowest
// matching ruleset, then replays the header and cuts the rest through.
module pspin_pkt_match_mc
  import pspin_pkt_match_mc_pkg::*;
#(
  parameter int UMATCH_WIDTH          = 32,
  parameter int UMATCH_ENTRIES        = 4,
  parameter int UMATCH_RULESETS       = 4,
  parameter int UMATCH_HDR_BEATS      = 2,
  parameter int AXIS_IF_DATA_WIDTH    = 512,
  parameter int AXIS_IF_KEEP_WIDTH    = AXIS_IF_DATA_WIDTH / 8,
  parameter int AXIS_IF_RX_ID_WIDTH   = 1,
  parameter int AXIS_IF_RX_DEST_WIDTH = 8,
  parameter int AXIS_IF_RX_USER_WIDTH = 97
) (
  input  logic                                   clk,
  input  logic                                   rstn,

  input  logic [AXIS_IF_DATA_WIDTH-1:0]          s_axis_nic_rx_tdata,
  input  logic [AXIS_IF_KEEP_WIDTH-1:0]          s_axis_nic_rx_tkeep,
  input  logic                                   s_axis_nic_rx_tvalid,
  output logic                                   s_axis_nic_rx_tready,
  input  logic                                   s_axis_nic_rx_tlast,
  input  logic [AXIS_IF_RX_ID_WIDTH-1:0]         s_axis_nic_rx_tid,
  input  logic [AXIS_IF_RX_DEST_WIDTH-1:0]       s_axis_nic_rx_tdest,
  input  logic [AXIS_IF_RX_USER_WIDTH-1:0]       s_axis_nic_rx_tuser,

  output logic [AXIS_IF_DATA_WIDTH-1:0]          m_axis_nic_rx_tdata,
  output logic [AXIS_IF_KEEP_WIDTH-1:0]          m_axis_nic_rx_tkeep,
  output logic                                   m_axis_nic_rx_tvalid,
  input  logic                                   m_axis_nic_rx_tready,
  output logic                                   m_axis_nic_rx_tlast,
  output logic [AXIS_IF_RX_ID_WIDTH-1:0]         m_axis_nic_rx_tid,
  output logic [AXIS_IF_RX_DEST_WIDTH-1:0]       m_axis_nic_rx_tdest,
  output logic [AXIS_IF_RX_USER_WIDTH-1:0]       m_axis_nic_rx_tuser,

  output logic [AXIS_IF_DATA_WIDTH-1:0]          m_axis_pspin_rx_tdata,
  output logic [AXIS_IF_KEEP_WIDTH-1:0]          m_axis_pspin_rx_tkeep,
  output logic                                   m_axis_pspin_rx_tvalid,
  input  logic                                   m_axis_pspin_rx_tready,
  output logic                                   m_axis_pspin_rx_tlast,
  output logic [AXIS_IF_RX_ID_WIDTH-1:0]         m_axis_pspin_rx_tid,
  output logic [AXIS_IF_RX_DEST_WIDTH-1:0]       m_axis_pspin_rx_tdest,
  output logic [AXIS_IF_RX_USER_WIDTH-1:0]       m_axis_pspin_rx_tuser,

  input  logic [UMATCH_RULESETS-1:0]                             match_mode,
  input  logic [UMATCH_WIDTH*UMATCH_ENTRIES*UMATCH_RULESETS-1:0] match_idx,
  input  logic [UMATCH_WIDTH*UMATCH_ENTRIES*UMATCH_RULESETS-1:0] match_mask,
  input  logic [UMATCH_WIDTH*UMATCH_ENTRIES*UMATCH_RULESETS-1:0] match_start,
  input  logic [UMATCH_WIDTH*UMATCH_ENTRIES*UMATCH_RULESETS-1:0] match_end,
  input  logic                                                   match_valid,

  output logic [31:0]                            stat_matched_pkts,
  output logic [31:0]                            stat_unmatched_pkts
);

  localparam int NRULES = UMATCH_ENTRIES * UMATCH_RULESETS;
  localparam int RS_W   = clog2_min1(UMATCH_RULESETS);
  localparam int IDX_W  = clog2_min1(UMATCH_HDR_BEATS);
  localparam int CNT_W  = $clog2(UMATCH_HDR_BEATS + 1);
  localparam int HB     = UMATCH_HDR_BEATS;

  state_e state_q, state_d;
  logic   run_q;

  logic [HB-1:0][AXIS_IF_DATA_WIDTH-1:0]    buf_data;
  logic [HB-1:0][AXIS_IF_KEEP_WIDTH-1:0]    buf_keep;
  logic [HB-1:0]                            buf_last;
  logic [HB-1:0][AXIS_IF_RX_ID_WIDTH-1:0]   buf_id;
  logic [HB-1:0][AXIS_IF_RX_DEST_WIDTH-1:0] buf_dest;
  logic [HB-1:0][AXIS_IF_RX_USER_WIDTH-1:0] buf_user;

  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] rd_q, wr_ptr;
  logic             wr_en;

  logic [UMATCH_RULESETS-1:0]           mode_q;
  logic [NRULES-1:0][UMATCH_WIDTH-1:0]  idx_q, mask_q, start_q, end_q;

  logic [UMATCH_RULESETS-1:0][UMATCH_ENTRIES-1:0] hit, en;
  logic [UMATCH_RULESETS-1:0] rs_hit;
  logic                       found;
  logic [RS_W-1:0]            win_d, win_q;
  logic                       sel_pspin_q;
  logic [AXIS_IF_RX_DEST_WIDTH-1:0] win_dest;

  logic                             o_valid, o_rdy, o_last, done_pkt;
  logic [AXIS_IF_DATA_WIDTH-1:0]    o_data;
  logic [AXIS_IF_KEEP_WIDTH-1:0]    o_keep;
  logic [AXIS_IF_RX_ID_WIDTH-1:0]   o_id;
  logic [AXIS_IF_RX_DEST_WIDTH-1:0] o_dest;
  logic [AXIS_IF_RX_USER_WIDTH-1:0] o_user;

  logic [31:0] matched_cnt, unmatched_cnt;

  // One compare unit per rule slot, all looking at the latched header.
  for (genvar r = 0; r < UMATCH_RULESETS; r++) begin : g_rs
    for (genvar e = 0; e < UMATCH_ENTRIES; e++) begin : g_ent
      pspin_match_unit #(
        .UMATCH_WIDTH       (UMATCH_WIDTH),
        .AXIS_IF_DATA_WIDTH (AXIS_IF_DATA_WIDTH),
        .UMATCH_HDR_BEATS   (HB),
        .CNT_W              (CNT_W)
      ) u_unit (
        .hdr        (buf_data),
        .nbeats     (cnt_q),
        .mode       (mode_q[r]),
        .idx        (idx_q[r*UMATCH_ENTRIES+e]),
        .mask       (mask_q[r*UMATCH_ENTRIES+e]),
        .rule_start (start_q[r*UMATCH_ENTRIES+e]),
        .rule_end   (end_q[r*UMATCH_ENTRIES+e]),
        .en         (en[r][e]),
        .hit        (hit[r][e])
      );
    end
  end

  always_comb begin
    rs_hit = '0;
    for (int r = 0; r < UMATCH_RULESETS; r++)
      rs_hit[r] = (|en[r]) && ((mode_q[r] == MODE_OR) ? |hit[r] : &hit[r]);
    found = 1'b0;
    win_d = '0;
    // Descending scan so the lowest index ends up as the winner.
    for (int r = UMATCH_RULESETS - 1; r >= 0; r--)
      if (rs_hit[r]) begin
        found = 1'b1;
        win_d = RS_W'(r);
      end
  end

  always_comb begin
    win_dest           = '0;
    win_dest[RS_W-1:0] = win_q;
  end

  assign wr_ptr = (state_q == IDLE) ? '0 : cnt_q[IDX_W-1:0];
  assign o_rdy  = sel_pspin_q ? m_axis_pspin_rx_tready : m_axis_nic_rx_tready;

  always_comb begin
    state_d              = state_q;
    s_axis_nic_rx_tready = 1'b0;
    wr_en                = 1'b0;
    o_valid              = 1'b0;
    o_data               = '0;
    o_keep               = '0;
    o_last               = 1'b0;
    o_id                 = '0;
    o_dest               = '0;
    o_user               = '0;
    unique case (state_q)
      IDLE: begin
        s_axis_nic_rx_tready = run_q;
        if (run_q && s_axis_nic_rx_tvalid) begin
          wr_en   = 1'b1;
          state_d = (s_axis_nic_rx_tlast || HB == 1) ? MATCH : HDR;
        end
      end
      HDR: begin
        s_axis_nic_rx_tready = 1'b1;
        if (s_axis_nic_rx_tvalid) begin
          wr_en = 1'b1;
          if (s_axis_nic_rx_tlast || cnt_q == CNT_W'(HB - 1)) state_d = MATCH;
        end
      end
      MATCH: state_d = FLUSH;
      FLUSH: begin
        o_valid = 1'b1;
        o_data  = buf_data[rd_q];
        o_keep  = buf_keep[rd_q];
        o_last  = buf_last[rd_q];
        o_id    = buf_id[rd_q];
        o_dest  = sel_pspin_q ? win_dest : buf_dest[rd_q];
        o_user  = buf_user[rd_q];
        if (o_rdy && CNT_W'(rd_q) == cnt_q - CNT_W'(1))
          state_d = buf_last[rd_q] ? IDLE : PASS;
      end
      PASS: begin
        s_axis_nic_rx_tready = o_rdy;
        o_valid = s_axis_nic_rx_tvalid;
        o_data  = s_axis_nic_rx_tdata;
        o_keep  = s_axis_nic_rx_tkeep;
        o_last  = s_axis_nic_rx_tlast;
        o_id    = s_axis_nic_rx_tid;
        o_dest  = sel_pspin_q ? win_dest : s_axis_nic_rx_tdest;
        o_user  = s_axis_nic_rx_tuser;
        if (s_axis_nic_rx_tvalid && o_rdy && s_axis_nic_rx_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done_pkt = o_valid && o_rdy && o_last;

  always_comb begin
    m_axis_nic_rx_tvalid   = 1'b0;
    m_axis_nic_rx_tdata    = '0;
    m_axis_nic_rx_tkeep    = '0;
    m_axis_nic_rx_tlast    = 1'b0;
    m_axis_nic_rx_tid      = '0;
    m_axis_nic_rx_tdest    = '0;
    m_axis_nic_rx_tuser    = '0;
    m_axis_pspin_rx_tvalid = 1'b0;
    m_axis_pspin_rx_tdata  = '0;
    m_axis_pspin_rx_tkeep  = '0;
    m_axis_pspin_rx_tlast  = 1'b0;
    m_axis_pspin_rx_tid    = '0;
    m_axis_pspin_rx_tdest  = '0;
    m_axis_pspin_rx_tuser  = '0;
    if (sel_pspin_q) begin
      m_axis_pspin_rx_tvalid = o_valid;
      m_axis_pspin_rx_tdata  = o_data;
      m_axis_pspin_rx_tkeep  = o_keep;
      m_axis_pspin_rx_tlast  = o_last;
      m_axis_pspin_rx_tid    = o_id;
      m_axis_pspin_rx_tdest  = o_dest;
      m_axis_pspin_rx_tuser  = o_user;
    end else begin
      m_axis_nic_rx_tvalid   = o_valid;
      m_axis_nic_rx_tdata    = o_data;
      m_axis_nic_rx_tkeep    = o_keep;
      m_axis_nic_rx_tlast    = o_last;
      m_axis_nic_rx_tid      = o_id;
      m_axis_nic_rx_tdest    = o_dest;
      m_axis_nic_rx_tuser    = o_user;
    end
  end

  // Header storage carries no reset: only beats below cnt_q are ever read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_data[wr_ptr] <= s_axis_nic_rx_tdata;
      buf_keep[wr_ptr] <= s_axis_nic_rx_tkeep;
      buf_last[wr_ptr] <= s_axis_nic_rx_tlast;
      buf_id[wr_ptr]   <= s_axis_nic_rx_tid;
      buf_dest[wr_ptr] <= s_axis_nic_rx_tdest;
      buf_user[wr_ptr] <= s_axis_nic_rx_tuser;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      run_q         <= 1'b0;
      cnt_q         <= '0;
      rd_q          <= '0;
      mode_q        <= '0;
      idx_q         <= '0;
      mask_q        <= '0;
      start_q       <= '0;
      end_q         <= '0;
      sel_pspin_q   <= 1'b0;
      win_q         <= '0;
      matched_cnt   <= '0;
      unmatched_cnt <= '0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (wr_en) cnt_q <= (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
      // Rules are frozen at the first beat so later changes cannot leak in.
      if (wr_en && state_q == IDLE) begin
        mode_q  <= match_valid ? match_mode  : '0;
        idx_q   <= match_valid ? match_idx   : '0;
        mask_q  <= match_valid ? match_mask  : '0;
        start_q <= match_valid ? match_start : '0;
        end_q   <= match_valid ? match_end   : '0;
      end
      if (state_q == MATCH) begin
        sel_pspin_q <= found;
        win_q       <= win_d;
        rd_q        <= '0;
      end
      if (state_q == FLUSH && o_rdy) rd_q <= rd_q + IDX_W'(1);
      if (done_pkt) begin
        if (sel_pspin_q) matched_cnt   <= matched_cnt + 32'd1;
        else             unmatched_cnt <= unmatched_cnt + 32'd1;
      end
    end
  end

  assign stat_matched_pkts   = matched_cnt;
  assign stat_unmatched_pkts = unmatched_cnt;

endmodule

// File: tb/tb_pspin_pkt_match_mc.sv
// Scoreboard bench: packet-level reference model predicts route/tdest per beat,
// monitors pop and compare on every output handshake.
module tb_pspin_pkt_match_mc;

  localparam int W = 32, E = 4, R = 4, HB = 2, DW = 512, KW = 64;
  localparam int IW = 1, DSW = 8, UW = 97, NR = E * R, WPB = DW / W;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [KW-1:0]  keep;
    logic           last;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
  } beat_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata;  logic [KW-1:0] s_tkeep; logic s_tvalid, s_tready, s_tlast;
  logic [IW-1:0] s_tid;    logic [DSW-1:0] s_tdest; logic [UW-1:0] s_tuser;
  logic [DW-1:0] n_tdata;  logic [KW-1:0] n_tkeep; logic n_tvalid, n_tready, n_tlast;
  logic [IW-1:0] n_tid;    logic [DSW-1:0] n_tdest; logic [UW-1:0] n_tuser;
  logic [DW-1:0] p_tdata;  logic [KW-1:0] p_tkeep; logic p_tvalid, p_tready, p_tlast;
  logic [IW-1:0] p_tid;    logic [DSW-1:0] p_tdest; logic [UW-1:0] p_tuser;
  logic [R-1:0] match_mode;
  logic [NR-1:0][W-1:0] r_idx, r_mask, r_start, r_end;
  logic match_valid;
  logic [31:0] stat_matched_pkts, stat_unmatched_pkts;

  pspin_pkt_match_mc dut (
    .clk(clk), .rstn(rstn),
    .s_axis_nic_rx_tdata(s_tdata), .s_axis_nic_rx_tkeep(s_tkeep), .s_axis_nic_rx_tvalid(s_tvalid),
    .s_axis_nic_rx_tready(s_tready), .s_axis_nic_rx_tlast(s_tlast), .s_axis_nic_rx_tid(s_tid),
    .s_axis_nic_rx_tdest(s_tdest), .s_axis_nic_rx_tuser(s_tuser),
    .m_axis_nic_rx_tdata(n_tdata), .m_axis_nic_rx_tkeep(n_tkeep), .m_axis_nic_rx_tvalid(n_tvalid),
    .m_axis_nic_rx_tready(n_tready), .m_axis_nic_rx_tlast(n_tlast), .m_axis_nic_rx_tid(n_tid),
    .m_axis_nic_rx_tdest(n_tdest), .m_axis_nic_rx_tuser(n_tuser),
    .m_axis_pspin_rx_tdata(p_tdata), .m_axis_pspin_rx_tkeep(p_tkeep), .m_axis_pspin_rx_tvalid(p_tvalid),
    .m_axis_pspin_rx_tready(p_tready), .m_axis_pspin_rx_tlast(p_tlast), .m_axis_pspin_rx_tid(p_tid),
    .m_axis_pspin_rx_tdest(p_tdest), .m_axis_pspin_rx_tuser(p_tuser),
    .match_mode(match_mode), .match_idx(r_idx), .match_mask(r_mask),
    .match_start(r_start), .match_end(r_end), .match_valid(match_valid),
    .stat_matched_pkts(stat_matched_pkts), .stat_unmatched_pkts(stat_unmatched_pkts)
  );

  int checks = 0, errors = 0;
  beat_t pq[$], nq[$];
  logic [31:0] exp_m = '0, exp_u = '0;
  logic [DW-1:0] hw [HB];
  bit bp_en = 1'b0;

  beat_t p_act, n_act, p_hold, n_hold;
  bit p_hold_v = 1'b0, n_hold_v = 1'b0;
  assign p_act = {p_tdata, p_tkeep, p_tlast, p_tid, p_tdest, p_tuser};
  assign n_act = {n_tdata, n_tkeep, n_tlast, n_tid, n_tdest, n_tuser};

  task automatic chk_beat(input string nm, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive tready away from the edge; random when backpressure is enabled.
  initial begin
    n_tready = 1'b0;
    p_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      n_tready = bp_en ? 1'($urandom % 2) : 1'b1;
      p_tready = bp_en ? 1'($urandom % 2) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      p_hold_v <= 1'b0;
    end else begin
      if (p_hold_v) begin
        chk32("pspin_hold_valid", {31'b0, p_tvalid}, 32'd1);
        chk_beat("pspin_hold_data", p_act, p_hold);
      end
      if (p_tvalid && p_tready) begin
        if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL pspin_unexpected: got %h expected nothing", p_act);
        end else chk_beat("pspin_beat", p_act, pq.pop_front());
      end
      if (n_tvalid) chk_beat("pspin_unselected_zero", p_act, '0);
      p_hold_v <= p_tvalid && !p_tready;
      p_hold   <= p_act;
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      n_hold_v <= 1'b0;
    end else begin
      if (n_hold_v) begin
        chk32("nic_hold_valid", {31'b0, n_tvalid}, 32'd1);
        chk_beat("nic_hold_data", n_act, n_hold);
      end
      if (n_tvalid && n_tready) begin
        if (nq.size() == 0) begin
          checks++; errors++;
          $display("FAIL nic_unexpected: got %h expected nothing", n_act);
        end else chk_beat("nic_beat", n_act, nq.pop_front());
      end
      if (p_tvalid) chk_beat("nic_unselected_zero", n_act, '0);
      n_hold_v <= n_tvalid && !n_tready;
      n_hold   <= n_act;
    end
  end

  // Reference: lowest ruleset whose enabled rules combine true; -1 means NIC.
  function automatic int model_winner(input int nb);
    for (int r = 0; r < R; r++) begin
      bit any, acc, h;
      logic [31:0] mk, ix, wd;
      any = 1'b0;
      acc = (match_mode[r] == 1'b0);
      for (int e = 0; e < E; e++) begin
        mk = r_mask[r*E+e];
        ix = r_idx[r*E+e];
        if (mk == 0) continue;
        any = 1'b1;
        h = 1'b0;
        if (ix < WPB * HB && int'(ix / WPB) < nb) begin
          wd = hw[ix / WPB][(ix % WPB) * W +: W] & mk;
          h = (wd >= r_start[r*E+e]) && (wd <= r_end[r*E+e]);
        end
        acc = match_mode[r] ? (acc | h) : (acc & h);
      end
      if (any && acc) return r;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic clear_rules();
    r_idx = '0; r_mask = '0; r_start = '0; r_end = '0; match_mode = '0;
  endtask

  task automatic set_rule(input int r, input int e, input logic [31:0] ix, mk, st, en);
    r_idx[r*E+e] = ix; r_mask[r*E+e] = mk; r_start[r*E+e] = st; r_end[r*E+e] = en;
  endtask

  task automatic randomize_rules();
    int lo;
    match_mode = 4'($urandom);
    for (int i = 0; i < NR; i++) begin
      r_idx[i] = $urandom_range(0, 40);
      if ($urandom % 4 == 0) begin
        r_mask[i] = '0; r_start[i] = $urandom; r_end[i] = $urandom;
      end else begin
        case ($urandom % 3)
          0: begin r_mask[i] = '1; r_start[i] = '0; r_end[i] = $urandom; end
          1: begin
            lo = $urandom_range(0, 200);
            r_mask[i] = 32'hFF; r_start[i] = lo; r_end[i] = $urandom_range(lo, 255);
          end
          default: begin r_mask[i] = $urandom; r_start[i] = '0; r_end[i] = $urandom; end
        endcase
      end
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0; #1;
    chk_beat("rst_pspin_zero", p_act, '0);
    chk_beat("rst_nic_zero", n_act, '0);
    chk32("rst_s_tready", {31'b0, s_tready}, 32'd0);
    chk32("rst_stat_matched", stat_matched_pkts, 32'd0);
    chk32("rst_stat_unmatched", stat_unmatched_pkts, 32'd0);
    pq.delete(); nq.delete();
    exp_m = '0; exp_u = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk32("s_tready_before_edge", {31'b0, s_tready}, 32'd0);
    @(negedge clk);
    chk32("s_tready_after_reset", {31'b0, s_tready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drive_beat(input beat_t b, output bit ok);
    bit acc;
    s_tdata = b.data; s_tkeep = b.keep; s_tlast = b.last;
    s_tid = b.id; s_tdest = b.dest; s_tuser = b.user; s_tvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk); #1;
      if (acc) begin ok = 1'b1; break; end
    end
    s_tvalid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL s_accept_timeout: got no tready expected accept");
    end
  endtask

  task automatic send_pkt(input int nb, input int pin_k, input logic [31:0] pin_v,
                          input bit mid_change, input int abort_at);
    beat_t bts[$];
    beat_t b;
    int win;
    bit ok;
    for (int i = 0; i < nb; i++) begin
      b.data = rand_data();
      b.keep = (i == nb - 1) ? ({$urandom, $urandom} | 64'h1) : '1;
      b.last = (i == nb - 1);
      b.id   = 1'($urandom);
      b.dest = 8'($urandom);
      b.user = 97'({$urandom, $urandom, $urandom, $urandom});
      if (pin_k >= 0 && pin_k / WPB == i) b.data[(pin_k % WPB) * W +: W] = pin_v;
      bts.push_back(b);
    end
    for (int i = 0; i < HB; i++) hw[i] = (i < nb) ? bts[i].data : '0;
    win = match_valid ? model_winner(nb) : -1;
    if (abort_at == 0) begin
      if (win >= 0) exp_m = exp_m + 1;
      else          exp_u = exp_u + 1;
    end
    foreach (bts[i]) begin
      b = bts[i];
      if (win >= 0) begin b.dest = 8'(win); pq.push_back(b); end
      else nq.push_back(b);
    end
    for (int i = 0; i < nb; i++) begin
      drive_beat(bts[i], ok);
      if (!ok) return;
      if (i == 0 && mid_change) begin
        match_valid = ~match_valid;
        randomize_rules();
      end
      if (abort_at == i + 1) begin
        apply_reset();
        return;
      end
      if ($urandom % 4 == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain_check(input string nm);
    int n = 0;
    while ((pq.size() != 0 || nq.size() != 0) && n < 5000) begin
      @(negedge clk); n++;
    end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL %s_drain_timeout: got %0d/%0d beats left expected 0", nm, pq.size(), nq.size());
      pq.delete(); nq.delete();
    end
    repeat (3) @(negedge clk);
    chk32({nm, "_stat_matched"}, stat_matched_pkts, exp_m);
    chk32({nm, "_stat_unmatched"}, stat_unmatched_pkts, exp_u);
    @(posedge clk); #1;
  endtask

  initial begin
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tid = '0; s_tdest = '0; s_tuser = '0;
    match_valid = 1'b0;
    clear_rules();
    apply_reset();

    // ruleset 0 AND, single range rule on word 3
    match_valid = 1'b1;
    set_rule(0, 0, 3, 32'hFFFF_0000, 32'h0800_0000, 32'h0800_0000);
    send_pkt(2, 3, 32'h0800_ABCD, 1'b0, 0);
    drain_check("t_and_hit");

    // rulesets 1 and 2 both match; ruleset 0 only has an out-of-window rule
    clear_rules();
    set_rule(0, 0, 40, 32'h1, 32'h0, 32'h1);
    set_rule(1, 0, 5, '1, '0, '1);
    set_rule(2, 1, 7, '1, '0, '1);
    bp_en = 1'b1;
    send_pkt(4, -1, '0, 1'b0, 0);
    drain_check("t_lowest_wins");

    // OR rule beyond the single captured beat
    clear_rules();
    match_mode = 4'b0001;
    set_rule(0, 0, 20, '1, '0, '1);
    send_pkt(1, -1, '0, 1'b0, 0);
    drain_check("t_out_of_window");

    // rules invalid: everything to NIC, then a mid-packet rule change
    clear_rules();
    set_rule(1, 0, 5, '1, '0, '1);
    match_valid = 1'b0;
    for (int i = 0; i < 3; i++) send_pkt($urandom_range(1, 4), -1, '0, 1'b0, 0);
    drain_check("t_match_invalid");
    match_valid = 1'b1;
    send_pkt(3, -1, '0, 1'b1, 0);
    drain_check("t_mid_change");

    for (int i = 0; i < 40; i++) begin
      randomize_rules();
      match_valid = ($urandom % 8) != 0;
      send_pkt($urandom_range(1, 6), -1, '0, ($urandom % 4) == 0, 0);
    end
    drain_check("t_random");

    // reset during cut-through, then a normal packet
    clear_rules();
    set_rule(1, 0, 5, '1, '0, '1);
    match_valid = 1'b1;
    send_pkt(5, -1, '0, 1'b0, 3);
    send_pkt(2, -1, '0, 1'b0, 0);
    drain_check("t_reset_pass");

    // matched counter wrap via backdoor preload
    bp_en = 1'b0;
    dut.matched_cnt = 32'hFFFF_FFFF;
    exp_m = 32'hFFFF_FFFF;
    send_pkt(2, -1, '0, 1'b0, 0);
    drain_check("t_wrap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pspin_pkt_match_mc.md
PSPIN_PKT_MATCH_MC -- requirements
Module: pspin_pkt_match_mc

Interface
REQ-001 SHALL have parameter UMATCH_WIDTH, default 32, rule compare width in bits.
REQ-002 SHALL have parameter UMATCH_ENTRIES, default 4, rules per ruleset.
REQ-003 SHALL have parameter UMATCH_RULESETS, default 4, independent rulesets; power of two, at least 2.
REQ-004 SHALL have parameter UMATCH_HDR_BEATS, default 2, header window in beats.
REQ-005 SHALL have parameters AXIS_IF_DATA_WIDTH 512, AXIS_IF_KEEP_WIDTH DATA/8, AXIS_IF_RX_ID_WIDTH 1, AXIS_IF_RX_DEST_WIDTH 8, AXIS_IF_RX_USER_WIDTH 97.
REQ-006 SHALL have port clk, input, 1, sole clock.
REQ-007 SHALL have port rstn, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have s_axis_nic_rx_* inputs with tready output: tdata, tkeep, tvalid, tready, tlast, tid, tdest, tuser at parameter widths.
REQ-009 SHALL have m_axis_nic_rx_* outputs (unmatched) and m_axis_pspin_rx_* outputs (matched), each with an input tready, same signal set as REQ-008.
REQ-010 SHALL have match_mode, input, UMATCH_RULESETS bits, one per ruleset: 0 = AND, 1 = OR.
REQ-011 SHALL have match_idx, match_mask, match_start, match_end, each an input of UMATCH_WIDTH*UMATCH_ENTRIES*UMATCH_RULESETS bits; slot r*UMATCH_ENTRIES+e holds rule e of ruleset r.
REQ-012 SHALL have match_valid, input, 1, rule inputs valid.
REQ-013 SHALL have stat_matched_pkts and stat_unmatched_pkts, outputs, 32 bits each, packet counters.

Function
REQ-014 SHALL implement states IDLE, HDR, MATCH, FLUSH and PASS.
REQ-015 IDLE SHALL assert s tready; on first beat accept go to HDR (or MATCH if tlast), and latch all rule inputs, or all-zero rules if match_valid=0.
REQ-016 HDR SHALL store beats into the header buffer until UMATCH_HDR_BEATS are held or tlast is accepted, then go to MATCH.
REQ-017 MATCH SHALL last exactly 1 cycle with s tready=0, registering the decision; first output beat SHALL be valid the following cycle.
REQ-018 Rule evaluation: word = header word[idx] & mask, where word[k] = header bits [k*W +: W]; hit = start <= word <= end, unsigned.
REQ-019 Rule with mask 0 SHALL be disabled and yield 1 under AND and 0 under OR.
REQ-020 Enabled rule with idx beyond captured beats or beyond the window SHALL yield 0.
REQ-021 Ruleset with all masks 0 SHALL never match.
REQ-022 Lowest-index matching ruleset SHALL win; with no match the packet goes to NIC.
REQ-023 FLUSH SHALL emit buffered beats in order, with original tkeep/tid/tuser/tlast, on the selected output; advance only on tvalid&&tready.
REQ-024 Matched packets SHALL carry tdest = winning ruleset index zero-extended; unmatched keep original tdest.
REQ-025 After the last buffered beat: if that beat had tlast go to IDLE, else go to PASS.
REQ-026 PASS SHALL connect s to the selected output combinationally (tvalid, data, tready); go to IDLE on tlast accept.
REQ-027 Non-selected output SHALL drive tvalid=0 and all other signals 0.
REQ-028 Counters SHALL increment once per packet, in the cycle its tlast is accepted at the output, and wrap at 2^32.
REQ-029 Rule input changes mid-packet SHALL not affect the in-flight packet.
REQ-030 Outputs SHALL hold stable under backpressure until tready.

Reset
REQ-031 rstn low SHALL asynchronously force state IDLE, all tvalid/tready/tlast 0, data 0, counters 0, and latched rules 0.
REQ-032 Reset mid-packet SHALL discard the packet; the first beat after reset SHALL be treated as a packet start.
REQ-033 s tready SHALL rise the first cycle after rstn deasserts.

Structure
REQ-034 Mode encodings (AND=0, OR=1) and state encodings SHALL live in a shared package/header.
REQ-035 One sub-module, pspin_match_unit (single-rule compare incl. disable/out-of-window logic), SHALL be instantiated UMATCH_ENTRIES*UMATCH_RULESETS times.

Verification
REQ-036 Ruleset 0 AND, rule idx 3 mask FFFF0000 start/end 08000000; word3=0800ABCD -> pspin, tdest 0, stat_matched_pkts=1.
REQ-037 Rulesets 1 and 2 both match a 4-beat packet -> pspin, tdest 1, beats 3-4 cut through with tready toggling, no loss or reorder.
REQ-038 1-beat packet, rule idx 20 (beat 2, W=32) enabled, OR mode -> NIC, original tdest, stat_unmatched_pkts=1.
REQ-039 match_valid=0 during 3 packets -> all to NIC, stat_unmatched_pkts=3; match_valid toggled mid-packet -> decision unchanged.
REQ-040 rstn pulsed low during PASS -> outputs 0 immediately, counters 0, next packet handled correctly.
REQ-041 Counter preload test: 2^32-1 matched packets forced via backdoor then one more -> stat_matched_pkts=0.
